dbg_icb_arbiter: RTL and testbench
==================================

Name: dbg_icb_arbiter

Overview:
- Shares the single ICB slave port of the debug module between REQ_NUM ICB masters, e.g. the AXI-to-ICB debug bridge and a system-bus-access requester.
- Round-robin grant; exactly one command outstanding at a time, because the debug module answers in order with no ID.
- Sits on the hfclk domain between the requesters and the debug module's ICB slave interface.

Parameters:
REQ_NUM, 2, number of requesting ICB masters (2..8)
ADDR_W, 12, ICB command address width
DATA_W, 32, ICB data width
TIMEOUT_CYC, 255, response watchdog limit in cycles (used only with the optional feature)

Ports:
hfclk  input  1  clock
corerst_n  input  1  asynchronous active-low reset
s_cmd_valid  input  REQ_NUM  per-requester command valid
s_cmd_ready  output  REQ_NUM  per-requester command ready
s_cmd_addr  input  REQ_NUM*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
s_cmd_read  input  REQ_NUM  1 = read, 0 = write
s_cmd_wdata  input  REQ_NUM*DATA_W  flattened write data
s_rsp_valid  output  REQ_NUM  per-requester response valid
s_rsp_ready  input  REQ_NUM  per-requester response ready
s_rsp_rdata  output  DATA_W  read data, broadcast to all requesters
s_rsp_err  output  1  response error flag, qualified by s_rsp_valid
m_cmd_valid  output  1  command valid to the debug module
m_cmd_ready  input  1  command ready from the debug module
m_cmd_addr  output  ADDR_W  command address
m_cmd_read  output  1  read flag
m_cmd_wdata  output  DATA_W  write data
m_rsp_valid  input  1  response valid from the debug module
m_rsp_ready  output  1  response ready to the debug module
m_rsp_rdata  input  DATA_W  response read data
busy  output  1  state != IDLE
grant_idx  output  $clog2(REQ_NUM)  currently granted requester

Behaviour:
- Clocking: all state on posedge hfclk, async clear on negedge corerst_n.
- Reset: state=IDLE, rr_ptr=0, grant_idx=0; every valid/ready output and s_rsp_err are 0.
- Reset mid-transaction drops the transaction. No replay.
- ICB rule: a requester holds s_cmd_valid and its payload stable until s_cmd_ready. The arbiter does not check this.
- IDLE:
  - If any s_cmd_valid, pick the first set bit searching upward from rr_ptr with wrap.
  - Register the pick into grant_idx and go to CMD. Decision to m_cmd_valid is 1 cycle.
  - All s_cmd_ready=0 and m_rsp_ready=0 in IDLE.
- CMD:
  - m_cmd_valid=1; m_cmd_* = the granted requester's fields, combinational mux.
  - s_cmd_ready[grant_idx]=m_cmd_ready; all other ready bits 0.
  - On m_cmd_valid&m_cmd_ready, go to RSP.
- RSP:
  - s_rsp_valid[grant_idx]=m_rsp_valid; s_rsp_rdata=m_rsp_rdata; m_rsp_ready=s_rsp_ready[grant_idx].
  - On the response handshake: rr_ptr=(grant_idx+1) mod REQ_NUM, then IDLE.
- Throughput: minimum 3 cycles per transaction (IDLE, CMD, RSP with the handshake in that cycle).
- m_rsp_ready is 0 outside RSP. A stray m_rsp_valid in IDLE/CMD stalls downstream and is not consumed.
- Simultaneous requests: the winner is the first set bit from rr_ptr. The loser's valid stays pending and is granted next if it is still asserted.
- Wrap: with rr_ptr=REQ_NUM-1, the search order is REQ_NUM-1, 0, 1, ...
- A requester dropping s_cmd_valid while in IDLE is simply not picked.
- s_rsp_rdata holds m_rsp_rdata when not valid; no zeroing.

Optional Feature:
- Macro: DBG_ICB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RSP and increments each RSP cycle without m_rsp_valid.
  - At TIMEOUT_CYC the arbiter goes to ERR.
  - ERR: s_rsp_valid[grant_idx]=1, s_rsp_rdata=ERR_RDATA (32'hDEAD_BEEF), s_rsp_err=1. On s_rsp_ready, advance rr_ptr, go IDLE and set drop_pending.
  - While drop_pending=1: m_rsp_ready=1 in IDLE and new grants are blocked.
  - drop_pending clears when a late response is sunk or after TIMEOUT_CYC further cycles, whichever comes first.
- When undefined: no counter, no ERR state, no drop_pending; s_rsp_err is tied 0.

Decomposition:
- Package dbg_icb_pkg:
  - state enum: IDLE, CMD, RSP, ERR
  - ERR_RDATA constant
  - typedef for the grant index width
- Sub-module dbg_rr_pick: combinational round-robin first-set search taking (req vector, rr_ptr) and returning (any, idx).
- Flop logic stays in dbg_icb_arbiter.

Test Plan:
- Single read, requester 0, addr 12'h044, debug module returns 32'h0000_0A5A: m_cmd_valid rises 1 cycle after s_cmd_valid[0]; s_rsp_valid[0] carries 32'h0000_0A5A; s_rsp_valid[1] stays 0.
- Both requesters valid at once from reset: grants in order 0, 1, 0, 1 over four back-to-back transactions; each takes ≥3 cycles.
- m_cmd_ready held low 5 cycles: m_cmd_addr/wdata stable; s_cmd_ready[0]=0 until cycle 6; no state change.
- s_rsp_ready low 4 cycles while m_rsp_valid=1: m_rsp_ready=0; stays in RSP; handshake on cycle 5, then IDLE.
- Assert corerst_n=0 in RSP: outputs 0 immediately (async); after release busy=0, rr_ptr=0, next grant goes to requester 0.
- With DBG_ICB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no response: s_rsp_err=1 with rdata 32'hDEAD_BEEF at cycle 16; a late m_rsp_valid is sunk; the next command is then granted normally.

Source files
------------

// File: rtl/dbg_icb_arbiter_pkg.sv
// Shared types and constants for the debug-module ICB arbiter.
package dbg_icb_pkg;

    // Arbiter phases; ERR is only reachable with DBG_ICB_ARB_TIMEOUT_EN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Read data returned on a synthesised (watchdog) error response.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Largest supported requester count and the index width it needs.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned GRANT_W = $clog2(MAX_REQ);
    typedef logic [GRANT_W-1:0] grant_t;

endpackage

// File: rtl/dbg_icb_arbiter_if.sv
// ICB bundle between the requesters, the arbiter and the debug module.
// "slave" is the arbiter's view; "master" is the environment's view.
interface dbg_icb_arbiter_if #(
    parameter int unsigned REQ_NUM = 2,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32
);
    logic [REQ_NUM-1:0]        s_cmd_valid;
    logic [REQ_NUM-1:0]        s_cmd_ready;
    logic [REQ_NUM*ADDR_W-1:0] s_cmd_addr;
    logic [REQ_NUM-1:0]        s_cmd_read;
    logic [REQ_NUM*DATA_W-1:0] s_cmd_wdata;
    logic [REQ_NUM-1:0]        s_rsp_valid;
    logic [REQ_NUM-1:0]        s_rsp_ready;
    logic [DATA_W-1:0]         s_rsp_rdata;
    logic                      s_rsp_err;
    logic                      m_cmd_valid;
    logic                      m_cmd_ready;
    logic [ADDR_W-1:0]         m_cmd_addr;
    logic                      m_cmd_read;
    logic [DATA_W-1:0]         m_cmd_wdata;
    logic                      m_rsp_valid;
    logic                      m_rsp_ready;
    logic [DATA_W-1:0]         m_rsp_rdata;

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_read, s_cmd_wdata, s_rsp_ready,
        input  m_cmd_ready, m_rsp_valid, m_rsp_rdata,
        output s_cmd_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err,
        output m_cmd_valid, m_cmd_addr, m_cmd_read, m_cmd_wdata, m_rsp_ready
    );

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_read, s_cmd_wdata, s_rsp_ready,
        output m_cmd_ready, m_rsp_valid, m_rsp_rdata,
        input  s_cmd_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err,
        input  m_cmd_valid, m_cmd_addr, m_cmd_read, m_cmd_wdata, m_rsp_ready
    );
endinterface

// File: rtl/dbg_icb_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or above ptr_i, with wrap.
module dbg_rr_pick #(
    parameter int unsigned REQ_NUM = 2,
    localparam int unsigned IdxW   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               any_o,
    output logic [IdxW-1:0]    idx_o
);

    // Scan from the farthest offset down so the nearest one to ptr_i wins.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int k = int'(REQ_NUM) - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % int'(REQ_NUM)]) begin
                idx_o = IdxW'((int'(ptr_i) + k) % int'(REQ_NUM));
            end
        end
    end

endmodule

// File: rtl/dbg_icb_arbiter.sv
// Round-robin arbiter sharing the debug module's ICB slave port between REQ_NUM masters.
// One command in flight at a time, since the debug module answers in order without IDs.
// Optional response watchdog: define DBG_ICB_ARB_TIMEOUT_EN.
module dbg_icb_arbiter
    import dbg_icb_pkg::*;
#(
    parameter int unsigned REQ_NUM     = 2,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       hfclk,
    input  logic                       corerst_n,
    dbg_icb_arbiter_if.slave           bus,
    output logic                       busy,
    output logic [$clog2(REQ_NUM)-1:0] grant_idx
);

    localparam int unsigned IdxW = $clog2(REQ_NUM);

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] grant_idx_q, grant_idx_d;
    logic [IdxW-1:0] grant_next;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    logic            rsp_hs;
    logic            grant_block;

    dbg_rr_pick #(
        .REQ_NUM (REQ_NUM)
    ) u_pick (
        .req_i (bus.s_cmd_valid),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign grant_next = (grant_idx_q == IdxW'(REQ_NUM - 1)) ? '0 : grant_idx_q + 1'b1;
    assign rsp_hs     = bus.m_rsp_valid & bus.s_rsp_ready[grant_idx_q];

`ifdef DBG_ICB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drop_pending_q, drop_pending_d;
    logic            cnt_done;

    assign cnt_done    = (cnt_q + 1'b1) == CntW'(TIMEOUT_CYC);
    assign grant_block = drop_pending_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYC == 0);
    assign grant_block = 1'b0;
`endif

    // Next-state: grant selection, handshake tracking and round-robin pointer advance.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
`ifdef DBG_ICB_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        drop_pending_d = drop_pending_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                // Sink the late response of a timed-out command, or give up waiting for it.
                if (drop_pending_q) begin
                    if (bus.m_rsp_valid || cnt_done) begin
                        drop_pending_d = 1'b0;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                if (pick_any && !grant_block) begin
                    grant_idx_d = pick_idx;
                    state_d     = CMD;
                end
            end
            CMD: begin
                if (bus.m_cmd_ready) begin
                    state_d = RSP;
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    rr_ptr_d = grant_next;
                    state_d  = IDLE;
                end
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                else if (!bus.m_rsp_valid) begin
                    if (cnt_done) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            ERR: begin
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                if (bus.s_rsp_ready[grant_idx_q]) begin
                    rr_ptr_d       = grant_next;
                    state_d        = IDLE;
                    drop_pending_d = 1'b1;
                    cnt_d          = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; an async reset drops any transaction in flight.
    always_ff @(posedge hfclk or negedge corerst_n) begin
        if (!corerst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
`ifdef DBG_ICB_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            drop_pending_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
`ifdef DBG_ICB_ARB_TIMEOUT_EN
            cnt_q          <= cnt_d;
            drop_pending_q <= drop_pending_d;
`endif
        end
    end

    // Output steering: only the granted requester sees ready/valid.
    always_comb begin
        bus.m_cmd_valid = 1'b0;
        bus.m_cmd_addr  = bus.s_cmd_addr[ADDR_W*grant_idx_q +: ADDR_W];
        bus.m_cmd_read  = bus.s_cmd_read[grant_idx_q];
        bus.m_cmd_wdata = bus.s_cmd_wdata[DATA_W*grant_idx_q +: DATA_W];
        bus.s_cmd_ready = '0;
        bus.s_rsp_valid = '0;
        bus.s_rsp_rdata = bus.m_rsp_rdata;
        bus.s_rsp_err   = 1'b0;
        bus.m_rsp_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                bus.m_rsp_ready = drop_pending_q;
`endif
            end
            CMD: begin
                bus.m_cmd_valid              = 1'b1;
                bus.s_cmd_ready[grant_idx_q] = bus.m_cmd_ready;
            end
            RSP: begin
                bus.s_rsp_valid[grant_idx_q] = bus.m_rsp_valid;
                bus.m_rsp_ready              = bus.s_rsp_ready[grant_idx_q];
            end
            ERR: begin
`ifdef DBG_ICB_ARB_TIMEOUT_EN
                bus.s_rsp_valid[grant_idx_q] = 1'b1;
                bus.s_rsp_rdata              = DATA_W'(ERR_RDATA);
                bus.s_rsp_err                = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_dbg_icb_arbiter.sv
// Bench for dbg_icb_arbiter: transaction-level ownership model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dbg_icb_arbiter;

    localparam int N = 2;

    logic       hfclk;
    logic       corerst_n;
    logic       busy;
    logic [0:0] grant_idx;

    dbg_icb_arbiter_if #(.REQ_NUM(N), .ADDR_W(12), .DATA_W(32)) bus ();

    dbg_icb_arbiter #(
        .REQ_NUM     (N),
        .ADDR_W      (12),
        .DATA_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .hfclk     (hfclk),
        .corerst_n (corerst_n),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial hfclk = 1'b0;
    always #5 hfclk = ~hfclk;

    int n_checks = 0;
    int n_err    = 0;
    bit model_on = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hfclk);
        #1;
    endtask

    // Model: who owns the debug port, and whether its command has been accepted yet.
    int m_owner;  // -1 when nobody owns it
    bit m_acc;
    int m_ptr;
    int m_last;

    always @(posedge hfclk or negedge corerst_n) begin
        if (!corerst_n) begin
            m_owner = -1;
            m_acc   = 1'b0;
            m_ptr   = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && bus.s_cmd_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_acc   = 1'b0;
                end
            end
        end else if (!m_acc) begin
            if (bus.m_cmd_ready) m_acc = 1'b1;
        end else if (bus.m_rsp_valid && bus.s_rsp_ready[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    end

    logic [N-1:0] e_scr, e_srv;
    logic         e_mcv, e_mrr;

    always @(negedge hfclk) begin
        if (model_on) begin
            e_mcv = (m_owner >= 0) && !m_acc;
            e_scr = '0;
            e_srv = '0;
            e_mrr = 1'b0;
            if (m_owner >= 0) begin
                if (!m_acc) begin
                    e_scr[m_owner] = bus.m_cmd_ready;
                end else begin
                    e_srv[m_owner] = bus.m_rsp_valid;
                    e_mrr          = bus.s_rsp_ready[m_owner];
                end
            end
            chk("busy", busy, m_owner >= 0);
            chk("grant_idx", grant_idx, m_last);
            chk("m_cmd_valid", bus.m_cmd_valid, e_mcv);
            chk("s_cmd_ready", bus.s_cmd_ready, e_scr);
            chk("s_rsp_valid", bus.s_rsp_valid, e_srv);
            chk("m_rsp_ready", bus.m_rsp_ready, e_mrr);
            chk("s_rsp_rdata", bus.s_rsp_rdata, bus.m_rsp_rdata);
            chk("s_rsp_err", bus.s_rsp_err, 1'b0);
            if (e_mcv) begin
                chk("m_cmd_addr", bus.m_cmd_addr, bus.s_cmd_addr[m_owner*12 +: 12]);
                chk("m_cmd_read", bus.m_cmd_read, bus.s_cmd_read[m_owner]);
                chk("m_cmd_wdata", bus.m_cmd_wdata, bus.s_cmd_wdata[m_owner*32 +: 32]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int g[$];
    int hs_t[$];

    initial begin
        corerst_n       = 1'b0;
        bus.s_cmd_valid = '0;
        bus.s_cmd_addr  = '0;
        bus.s_cmd_read  = '0;
        bus.s_cmd_wdata = '0;
        bus.s_rsp_ready = '0;
        bus.m_cmd_ready = 1'b0;
        bus.m_rsp_valid = 1'b0;
        bus.m_rsp_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_mcv", bus.m_cmd_valid, 0);
        chk("rst_srv", bus.s_rsp_valid, 0);
        corerst_n = 1'b1;

        // Single read from requester 0.
        bus.s_cmd_valid = 2'b01;
        bus.s_cmd_addr  = {12'h0, 12'h044};
        bus.s_cmd_read  = 2'b01;
        bus.m_cmd_ready = 1'b1;
        bus.s_rsp_ready = 2'b11;
        @(negedge hfclk);
        chk("t1_mcv_idle", bus.m_cmd_valid, 0);
        tick();
        @(negedge hfclk);
        chk("t1_mcv", bus.m_cmd_valid, 1);
        chk("t1_addr", bus.m_cmd_addr, 12'h044);
        chk("t1_scr", bus.s_cmd_ready, 2'b01);
        tick();
        bus.s_cmd_valid = 2'b00;
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_rdata = 32'h0000_0A5A;
        @(negedge hfclk);
        chk("t1_srv", bus.s_rsp_valid, 2'b01);
        chk("t1_rdata", bus.s_rsp_rdata, 32'h0000_0A5A);
        tick();
        bus.m_rsp_valid = 1'b0;
        @(negedge hfclk);
        chk("t1_idle", busy, 0);

        // Both requesters from reset, back to back, with a stray response valid held high.
        corerst_n = 1'b0;
        tick();
        corerst_n       = 1'b1;
        bus.s_cmd_valid = 2'b11;
        bus.s_cmd_addr  = {12'h2B0, 12'h1A0};
        bus.s_cmd_wdata = {32'h2222_2222, 32'h1111_1111};
        bus.s_cmd_read  = 2'b10;
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_rdata = 32'h0BAD_F00D;
        for (int c = 0; c < 40 && g.size() < 4; c++) begin
            @(negedge hfclk);
            if (bus.m_cmd_valid && bus.m_cmd_ready) begin
                g.push_back(int'(grant_idx));
                hs_t.push_back(c);
            end
            if (g.size() < 4) tick();
        end
        chk("rr_count", g.size(), 4);
        for (int k = 0; k < g.size(); k++) chk("rr_order", g[k], k % 2);
        for (int k = 1; k < hs_t.size(); k++) chk("rr_spacing", hs_t[k] - hs_t[k-1], 3);
        tick();
        bus.s_cmd_valid = 2'b00;
        tick();
        bus.m_rsp_valid = 1'b0;

        // Command stall: m_cmd_ready low for 5 cycles.
        bus.s_cmd_valid = 2'b01;
        bus.s_cmd_addr  = {12'h0, 12'h123};
        bus.s_cmd_wdata = {32'h0, 32'hCAFE_0001};
        bus.s_cmd_read  = 2'b00;
        bus.m_cmd_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge hfclk);
            chk("t3_addr", bus.m_cmd_addr, 12'h123);
            chk("t3_wdata", bus.m_cmd_wdata, 32'hCAFE_0001);
            chk("t3_scr", bus.s_cmd_ready, 2'b00);
            chk("t3_mcv", bus.m_cmd_valid, 1);
            tick();
        end
        bus.m_cmd_ready = 1'b1;
        @(negedge hfclk);
        chk("t3_scr6", bus.s_cmd_ready, 2'b01);
        tick();
        bus.s_cmd_valid = 2'b00;
        bus.m_cmd_ready = 1'b0;

        // Response stall: s_rsp_ready low for 4 cycles while m_rsp_valid is high.
        bus.m_rsp_valid = 1'b1;
        bus.m_rsp_rdata = 32'h0000_1111;
        bus.s_rsp_ready = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge hfclk);
            chk("t4_mrr", bus.m_rsp_ready, 0);
            chk("t4_srv", bus.s_rsp_valid, 2'b01);
            chk("t4_busy", busy, 1);
            tick();
        end
        bus.s_rsp_ready = 2'b01;
        @(negedge hfclk);
        chk("t4_mrr5", bus.m_rsp_ready, 1);
        tick();
        bus.m_rsp_valid = 1'b0;
        @(negedge hfclk);
        chk("t4_idle", busy, 0);

        // Reset while in RSP for requester 1.
        tick();
        bus.s_cmd_valid = 2'b10;
        bus.m_cmd_ready = 1'b1;
        tick();
        tick();
        bus.s_cmd_valid = 2'b00;
        bus.m_rsp_valid = 1'b1;
        bus.s_rsp_ready = 2'b00;
        @(negedge hfclk);
        chk("t5_srv_pre", bus.s_rsp_valid, 2'b10);
        chk("t5_grant_pre", grant_idx, 1);
        #2;
        corerst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_srv", bus.s_rsp_valid, 2'b00);
        chk("t5_mcv", bus.m_cmd_valid, 0);
        chk("t5_grant", grant_idx, 0);
        tick();
        corerst_n       = 1'b1;
        bus.m_rsp_valid = 1'b0;
        bus.s_cmd_valid = 2'b11;
        tick();
        @(negedge hfclk);
        chk("t5_grant_after", grant_idx, 0);
        chk("t5_mcv_after", bus.m_cmd_valid, 1);
        tick();
        bus.s_cmd_valid = 2'b00;
        bus.m_rsp_valid = 1'b1;
        bus.s_rsp_ready = 2'b11;
        tick();
        bus.m_rsp_valid = 1'b0;
        tick();

`ifdef DBG_ICB_ARB_TIMEOUT_EN
        // Watchdog: no response for 16 RSP cycles, then a late response is sunk.
        model_on  = 1'b0;
        corerst_n = 1'b0;
        tick();
        corerst_n       = 1'b1;
        bus.s_cmd_valid = 2'b01;
        bus.m_cmd_ready = 1'b1;
        bus.s_rsp_ready = 2'b01;
        bus.m_rsp_valid = 1'b0;
        tick();
        tick();
        bus.s_cmd_valid = 2'b00;
        for (int c = 0; c < 16; c++) begin
            @(negedge hfclk);
            chk("to_err_early", bus.s_rsp_err, 0);
            tick();
        end
        @(negedge hfclk);
        chk("to_err", bus.s_rsp_err, 1);
        chk("to_rdata", bus.s_rsp_rdata, 32'hDEAD_BEEF);
        chk("to_srv", bus.s_rsp_valid, 2'b01);
        tick();
        bus.s_cmd_valid = 2'b10;
        bus.m_rsp_valid = 1'b1;
        @(negedge hfclk);
        chk("to_sink_ready", bus.m_rsp_ready, 1);
        chk("to_blocked", busy, 0);
        tick();
        bus.m_rsp_valid = 1'b0;
        @(negedge hfclk);
        chk("to_drop_clear", bus.m_rsp_ready, 0);
        tick();
        @(negedge hfclk);
        chk("to_regrant", bus.m_cmd_valid, 1);
        chk("to_regrant_idx", grant_idx, 1);
        tick();
        bus.s_cmd_valid = 2'b00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
